flag_branch_ctrl: RTL and testbench
===================================

Name: flag_branch_ctrl

Overview:
- Condition-flag register and branch-resolution sequencer for the pipelined LEGv8 datapath.
- Latches the ALU's N/Z/C/V flags, including Z from the 64-bit zero detector, when a flag-setting instruction completes EX.
- Resolves B.cond, CBZ and CBNZ in ID.
- Generates stall and flush for the hazard unit, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
CNT_W, 16, width of stall-cycle performance counter
FLAG_W, 4, flag vector width, order {N,Z,C,V}; fixed at 4, parameter only for readability

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
ex_valid  input  1  EX-stage instruction valid
ex_set_flags  input  1  EX instruction sets flags (ADDS/SUBS/ANDS)
ex_flags  input  4  ALU flags {N,Z,C,V} from EX
id_valid  input  1  ID-stage instruction valid
id_bcond  input  1  ID instruction is B.cond
id_cond  input  4  B.cond condition code
id_cbz  input  1  ID instruction is CBZ
id_cbnz  input  1  ID instruction is CBNZ
id_reg_zero  input  1  zero-detect result on ID Rt operand (forwarded)
id_reg_ready  input  1  Rt forwarded value valid this cycle
flags_q  output  4  architectural flag register
br_taken  output  1  branch in ID resolved taken this cycle (combinational)
stall  output  1  hold PC and IF/ID this cycle (combinational)
flush  output  1  squash IF/ID contents (registered)
stall_cycles  output  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset (reset=0, asynchronous): flags_q=0000, FSM=RUN, flush=0, stall_cycles=0. br_taken=0 and stall=0 whenever FSM is not RUN/HOLD-evaluating.
- Flag write: at posedge, if ex_valid&ex_set_flags, flags_q<=ex_flags. No other writer.
- Condition decode (f=flags):
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !(C&!Z); A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE !(!Z&(N==V))
  - E AL 1; F NV 1 (treated as always)
- Branch class: br = id_valid&(id_bcond|id_cbz|id_cbnz). Exactly one type bit is set when br=1; multiple bits is illegal and need not be handled.
- FSM states:
  - RUN:
    - Flag hazard = br&id_bcond&ex_valid&ex_set_flags → stall=1, br_taken=0, next HOLD.
    - Operand hazard = br&(id_cbz|id_cbnz)&!id_reg_ready → stall=1, stay RUN.
    - Otherwise resolve:
      - B.cond uses flags_q.
      - CBZ taken=id_reg_zero.
      - CBNZ taken=!id_reg_zero.
      - If taken: br_taken=1, next FLUSH.
  - HOLD: ID instruction unchanged, flags_q now holds the new flags. Resolve B.cond with flags_q, stall=0. Taken → FLUSH, else RUN.
  - FLUSH: flush=1 for exactly one cycle. ID contents are wrong-path: id_valid is ignored, br_taken=0, stall=0. Next RUN.
- Latency: non-hazard branch resolves in 0 cycles; flag hazard costs 1 stall cycle; taken branch costs 1 flush cycle.
- Simultaneous events: a flag write in the same cycle as HOLD entry is captured before HOLD evaluates.
- stall_cycles: increments each cycle stall=1 and saturates at all-ones; it never wraps.
- Reset mid-HOLD or mid-FLUSH returns to RUN with flush=0 immediately.

Optional Feature:
- Macro FLAG_FWD_EN.
- Defined: on a flag hazard in RUN, evaluate B.cond directly from ex_flags. There is no stall and no HOLD; HOLD is unreachable.
- Undefined: behaviour as specified above, 1-cycle stall on flag hazard.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release → flags_q=0000, stall=0, flush=0, stall_cycles=0.
- Flag write then EQ: ex_set_flags with ex_flags=0100. Next cycle, id_bcond with id_cond=0 → br_taken=1 that cycle, flush=1 next cycle only, no stall.
- Flag hazard: same-cycle ex_set_flags with ex_flags=1000 and id_bcond with id_cond=B (LT).
  - Without FLAG_FWD_EN: stall=1 for 1 cycle, then br_taken=1, then flush=1; stall_cycles=1.
  - With FLAG_FWD_EN: br_taken=1 immediately, stall=0.
- CBZ operand not ready: id_cbz with id_reg_ready=0 for 2 cycles, then ready with id_reg_zero=1 → stall=1 for 2 cycles, then br_taken=1; stall_cycles=2.
- Wrong-path masking: during FLUSH cycle present id_bcond with id_cond=E → br_taken=0, stall=0, FSM returns to RUN.
- Counter saturation, with CNT_W=4: hold CBNZ with id_reg_ready=0 for 20 cycles → stall_cycles stops at 15.

Source files
------------

// File: rtl/flag_branch_ctrl.sv
// Condition-flag register and branch-resolution sequencer (B.cond, CBZ, CBNZ resolved in ID).
// Optional macro FLAG_FWD_EN: resolve a flag-hazard B.cond straight from ex_flags instead of stalling.
module flag_branch_ctrl #(
    parameter int CNT_W  = 16,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_set_flags,
    input  logic [FLAG_W-1:0] ex_flags,
    input  logic              id_valid,
    input  logic              id_bcond,
    input  logic [3:0]        id_cond,
    input  logic              id_cbz,
    input  logic              id_cbnz,
    input  logic              id_reg_zero,
    input  logic              id_reg_ready,
    output logic [FLAG_W-1:0] flags_q,
    output logic              br_taken,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FLUSH} state_t;

    state_t             r_state;
    logic [FLAG_W-1:0]  r_flags;
    logic               r_flush;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_br;
    logic               w_flag_haz;
    logic               w_op_haz;
    logic               w_flag_stall;
    logic [FLAG_W-1:0]  w_bcond_flags;
    logic               w_taken;
    logic               w_stall;
    logic               w_hold_go;

    // Flag order is {N,Z,C,V}; NV (F) behaves like AL.
    function automatic logic cond_eval(input logic [FLAG_W-1:0] f, input logic [3:0] c);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0:    cond_eval = z;
            4'h1:    cond_eval = ~z;
            4'h2:    cond_eval = cf;
            4'h3:    cond_eval = ~cf;
            4'h4:    cond_eval = n;
            4'h5:    cond_eval = ~n;
            4'h6:    cond_eval = v;
            4'h7:    cond_eval = ~v;
            4'h8:    cond_eval = cf & ~z;
            4'h9:    cond_eval = ~(cf & ~z);
            4'hA:    cond_eval = (n == v);
            4'hB:    cond_eval = (n != v);
            4'hC:    cond_eval = ~z & (n == v);
            4'hD:    cond_eval = ~(~z & (n == v));
            default: cond_eval = 1'b1;
        endcase
    endfunction

    assign w_br       = id_valid & (id_bcond | id_cbz | id_cbnz);
    assign w_flag_haz = w_br & id_bcond & ex_valid & ex_set_flags;
    assign w_op_haz   = w_br & (id_cbz | id_cbnz) & ~id_reg_ready;

`ifdef FLAG_FWD_EN
    assign w_bcond_flags = w_flag_haz ? ex_flags : r_flags;
    assign w_flag_stall  = 1'b0;
`else
    assign w_bcond_flags = r_flags;
    assign w_flag_stall  = w_flag_haz;
`endif

    always_comb begin
        w_taken   = 1'b0;
        w_stall   = 1'b0;
        w_hold_go = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_flag_stall) begin
                    w_stall   = 1'b1;
                    w_hold_go = 1'b1;
                end else if (w_op_haz) begin
                    w_stall = 1'b1;
                end else if (w_br) begin
                    if (id_bcond)
                        w_taken = cond_eval(w_bcond_flags, id_cond);
                    else if (id_cbz)
                        w_taken = id_reg_zero;
                    else
                        w_taken = ~id_reg_zero;
                end
            end
            // The stalled B.cond is still in ID and flags_q now carries the new flags.
            ST_HOLD: w_taken = id_valid & id_bcond & cond_eval(r_flags, id_cond);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_flush <= 1'b0;
            r_flags <= '0;
            r_cnt   <= '0;
        end else begin
            if (ex_valid && ex_set_flags)
                r_flags <= ex_flags;
            if (w_stall && !(&r_cnt))
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_flush <= w_taken;
            if (w_taken)
                r_state <= ST_FLUSH;
            else if (w_hold_go)
                r_state <= ST_HOLD;
            else
                r_state <= ST_RUN;
        end
    end

    assign flags_q      = r_flags;
    assign br_taken     = w_taken;
    assign stall        = w_stall;
    assign flush        = r_flush;
    assign stall_cycles = r_cnt;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Randomized self-checking bench for flag_branch_ctrl with a rule-level reference model.
module tb_flag_branch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ex_valid = 1'b0, ex_set_flags = 1'b0;
    logic [3:0] ex_flags = 4'h0;
    logic       id_valid = 1'b0, id_bcond = 1'b0, id_cbz = 1'b0, id_cbnz = 1'b0;
    logic [3:0] id_cond = 4'h0;
    logic       id_reg_zero = 1'b0, id_reg_ready = 1'b0;

    logic [3:0]  flags_q, flags_q_s;
    logic        br_taken, stall, flush, br_taken_s, stall_s, flush_s;
    logic [15:0] stall_cycles;
    logic [3:0]  stall_cycles_s;

    int total = 0;
    int bad   = 0;

    // Model state: expectations derived from what happened on the previous cycle.
    logic [3:0] m_flags;
    bit         m_flush;      // last cycle resolved a branch taken
    bit         m_hold;       // last cycle stalled a B.cond on in-flight flags
    int         m_cnt16, m_cnt4;

    flag_branch_ctrl #(.CNT_W(16), .FLAG_W(4)) u_dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
        .ex_flags(ex_flags), .id_valid(id_valid), .id_bcond(id_bcond), .id_cond(id_cond),
        .id_cbz(id_cbz), .id_cbnz(id_cbnz), .id_reg_zero(id_reg_zero),
        .id_reg_ready(id_reg_ready), .flags_q(flags_q), .br_taken(br_taken),
        .stall(stall), .flush(flush), .stall_cycles(stall_cycles)
    );

    flag_branch_ctrl #(.CNT_W(4), .FLAG_W(4)) u_sat (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
        .ex_flags(ex_flags), .id_valid(id_valid), .id_bcond(id_bcond), .id_cond(id_cond),
        .id_cbz(id_cbz), .id_cbnz(id_cbnz), .id_reg_zero(id_reg_zero),
        .id_reg_ready(id_reg_ready), .flags_q(flags_q_s), .br_taken(br_taken_s),
        .stall(stall_s), .flush(flush_s), .stall_cycles(stall_cycles_s)
    );

    always #5 clk = ~clk;

    // Condition table as pairs: odd codes invert the even base, except AL/NV.
    function automatic bit cond_ok(input logic [3:0] f, input logic [3:0] c);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c >= 4'hE) return 1'b1;
        return base ^ c[0];
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = 4'h0;
        m_flush = 0;
        m_hold  = 0;
        m_cnt16 = 0;
        m_cnt4  = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        {ex_valid, ex_set_flags, id_valid, id_bcond, id_cbz, id_cbnz} = '0;
        #1;
        model_reset();
        chk("rst_flags", flags_q, 0);
        chk("rst_flush", flush, 0);
        chk("rst_cnt", stall_cycles, 0);
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    // Drive one cycle of inputs, compare every output against the model, advance the model.
    task automatic step(input bit exv, input bit exs, input logic [3:0] exf,
                        input bit idv, input bit bc, input logic [3:0] cd,
                        input bit cz, input bit cnz, input bit rz, input bit rr);
        bit e_taken, e_stall, hold_next, br;
        @(negedge clk);
        ex_valid = exv; ex_set_flags = exs; ex_flags = exf;
        id_valid = idv; id_bcond = bc; id_cond = cd; id_cbz = cz; id_cbnz = cnz;
        id_reg_zero = rz; id_reg_ready = rr;
        #2;
        e_taken = 0; e_stall = 0; hold_next = 0;
        br = idv && (bc || cz || cnz);
        if (m_flush) begin
            e_taken = 0;
        end else if (m_hold) begin
            e_taken = idv && bc && cond_ok(m_flags, cd);
        end else if (br) begin
            if (bc) begin
                if (exv && exs) begin
`ifdef FLAG_FWD_EN
                    e_taken = cond_ok(exf, cd);
`else
                    e_stall = 1;
                    hold_next = 1;
`endif
                end else begin
                    e_taken = cond_ok(m_flags, cd);
                end
            end else if (!rr) begin
                e_stall = 1;
            end else begin
                e_taken = cz ? rz : !rz;
            end
        end
        chk("br_taken", br_taken, e_taken);
        chk("stall", stall, e_stall);
        chk("flush", flush, m_flush);
        chk("flags_q", flags_q, m_flags);
        chk("stall_cycles", stall_cycles, m_cnt16);
        chk("stall_cycles_w4", stall_cycles_s, m_cnt4);
        $display("cyc ex=%b%b/%h id=%b b%b c%h z%b nz%b rz%b rr%b -> tk=%b st=%b fl=%b f=%h cnt=%0d",
                 exv, exs, exf, idv, bc, cd, cz, cnz, rz, rr, br_taken, stall, flush, flags_q, stall_cycles);
        if (exv && exs) m_flags = exf;
        if (e_stall) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        m_flush = e_taken;
        m_hold  = hold_next;
    endtask

    initial begin
        bit pv, pb, pz, pnz;
        logic [3:0] pc;
        model_reset();
        // Reset held 3 cycles then released.
        do_reset(3);
        step(0,0,4'h0, 0,0,4'h0,0,0,0,0);
        chk("post_rst_stall", stall, 0);

        // Flag write then B.EQ: taken, one flush cycle, wrong-path AL ignored during flush.
        step(1,1,4'b0100, 0,0,4'h0,0,0,0,0);
        step(0,0,4'h0, 1,1,4'h0,0,0,0,0);
        chk("eq_taken", br_taken, 1);
        chk("eq_nostall", stall, 0);
        step(0,0,4'h0, 1,1,4'hE,0,0,0,0);
        chk("wp_flush", flush, 1);
        chk("wp_taken", br_taken, 0);
        chk("wp_stall", stall, 0);
        step(0,0,4'h0, 0,0,4'h0,0,0,0,0);
        chk("wp_flush_off", flush, 0);

        // Flag hazard with B.LT after N is set.
        do_reset(1);
        step(1,1,4'b1000, 1,1,4'hB,0,0,0,0);
`ifdef FLAG_FWD_EN
        chk("haz_fwd_taken", br_taken, 1);
        chk("haz_fwd_stall", stall, 0);
        step(0,0,4'h0, 0,0,4'h0,0,0,0,0);
        chk("haz_fwd_flush", flush, 1);
`else
        chk("haz_stall", stall, 1);
        chk("haz_taken0", br_taken, 0);
        step(0,0,4'h0, 1,1,4'hB,0,0,0,0);
        chk("hold_taken", br_taken, 1);
        chk("hold_stall", stall, 0);
        step(0,0,4'h0, 0,0,4'h0,0,0,0,0);
        chk("haz_flush", flush, 1);
        chk("haz_cnt", stall_cycles, 1);
`endif

        // CBZ waits two cycles on its operand.
        do_reset(1);
        step(0,0,4'h0, 1,0,4'h0,1,0,1,0);
        step(0,0,4'h0, 1,0,4'h0,1,0,1,0);
        chk("cbz_stall2", stall, 1);
        step(0,0,4'h0, 1,0,4'h0,1,0,1,1);
        chk("cbz_taken", br_taken, 1);
        chk("cbz_cnt", stall_cycles, 2);

        // Counter saturation: 20 stalled cycles.
        do_reset(1);
        repeat (20) step(0,0,4'h0, 1,0,4'h0,0,1,0,0);
        step(0,0,4'h0, 0,0,4'h0,0,0,0,0);
        chk("sat_w4", stall_cycles_s, 15);
        chk("sat_w16", stall_cycles, 20);

        // Randomized traffic with occasional mid-stream resets.
        pv = 0; pb = 0; pz = 0; pnz = 0; pc = 0;
        for (int i = 0; i < 1500; i++) begin
            bit v, b, z, nz;
            logic [3:0] c;
            int t;
            if ($urandom_range(0, 99) < 2) begin
                do_reset($urandom_range(1, 2));
                pv = 0; pb = 0; pz = 0; pnz = 0;
            end
            if (m_hold) begin
                v = pv; b = pb; c = pc; z = pz; nz = pnz;
            end else begin
                t  = $urandom_range(0, 3);
                v  = ($urandom_range(0, 9) < 8);
                b  = (t == 1); z = (t == 2); nz = (t == 3);
                c  = 4'($urandom_range(0, 15));
            end
            pv = v; pb = b; pc = c; pz = z; pnz = nz;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 v, b, c, z, nz, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
